// File: rtl/mem_arbiter_if.sv
// Shared access-op encodings and the requester/memory bundle of mem_arbiter.
// The load/store buffer and the bench both import these encodings.
package mem_arbiter_pkg;
  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;
endpackage

interface mem_arbiter_if;
  logic        io_buffer_full;
  logic        lsb_store;
  logic [31:0] store_address;
  logic [31:0] data_store;
  logic [5:0]  op_type_store;
  logic        finish_store;
  logic        lsb_load;
  logic [31:0] load_address;
  logic [5:0]  op_type_load;
  logic        finish_load;
  logic [31:0] data_load;
  logic        ifetch_req;
  logic [31:0] ifetch_addr;
  logic        ifetch_done;
  logic [31:0] ifetch_inst;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  io_buffer_full,
    input  lsb_store, store_address, data_store, op_type_store,
    output finish_store,
    input  lsb_load, load_address, op_type_load,
    output finish_load, data_load,
    input  ifetch_req, ifetch_addr,
    output ifetch_done, ifetch_inst,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output io_buffer_full,
    output lsb_store, store_address, data_store, op_type_store,
    input  finish_store,
    output lsb_load, load_address, op_type_load,
    input  finish_load, data_load,
    output ifetch_req, ifetch_addr,
    input  ifetch_done, ifetch_inst,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port owner: store > load > fetch arbitration, byte
// serialisation and little-endian read assembly with sign/zero extension.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          roll_back,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STORE = 3'd1,
    S_LOAD  = 3'd2,
    S_FETCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  r_len, w_len_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [23:0] r_wdata_hi, w_wdata_hi_nxt;
  logic [5:0]  r_op, w_op_nxt;
  logic [23:0] r_rbuf, w_rbuf_nxt;

  logic [31:0] r_mem_a, w_mem_a_nxt;
  logic        r_mem_wr, w_mem_wr_nxt;
  logic [7:0]  r_mem_dout, w_mem_dout_nxt;
  logic        r_finish_store, w_finish_store_nxt;
  logic        r_finish_load, w_finish_load_nxt;
  logic        r_ifetch_done, w_ifetch_done_nxt;
  logic [31:0] r_data_load, w_data_load_nxt;
  logic [31:0] r_ifetch_inst, w_ifetch_inst_nxt;

  logic        w_store_ok;
  logic [2:0]  w_cnt_inc;
  logic [31:0] w_addr_inc;
  logic [7:0]  w_wbyte;

  function automatic logic [2:0] f_len(input logic [5:0] op);
    case (op)
      OP_SB, OP_LB, OP_LBU: f_len = 3'd1;
      OP_SH, OP_LH, OP_LHU: f_len = 3'd2;
      OP_SW, OP_LW:         f_len = 3'd4;
      default:              f_len = 3'd4;
    endcase
  endfunction

  // The final byte is taken straight from mem_din in the cycle it arrives.
  function automatic logic [31:0] f_extend(input logic [5:0]  op,
                                           input logic [2:0]  len,
                                           input logic [7:0]  din,
                                           input logic [23:0] buf_in);
    logic [31:0] raw;
    case (len)
      3'd1:    raw = {24'd0, din};
      3'd2:    raw = {16'd0, din, buf_in[7:0]};
      default: raw = {din, buf_in};
    endcase
    if (op == OP_LB)      raw = {{24{raw[7]}}, raw[7:0]};
    else if (op == OP_LH) raw = {{16{raw[15]}}, raw[15:0]};
    return raw;
  endfunction

  assign w_store_ok = bus.lsb_store &&
                      !(bus.io_buffer_full && (bus.store_address[17:16] == IO_ADDR_HI));
  assign w_cnt_inc  = r_cnt + 3'd1;
  assign w_addr_inc = r_addr + {29'd0, w_cnt_inc};

  always_comb begin
    case (w_cnt_inc)
      3'd1:    w_wbyte = r_wdata_hi[7:0];
      3'd2:    w_wbyte = r_wdata_hi[15:8];
      default: w_wbyte = r_wdata_hi[23:16];
    endcase
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_len_nxt          = r_len;
    w_addr_nxt         = r_addr;
    w_wdata_hi_nxt     = r_wdata_hi;
    w_op_nxt           = r_op;
    w_rbuf_nxt         = r_rbuf;
    w_mem_a_nxt        = '0;
    w_mem_wr_nxt       = 1'b0;
    w_mem_dout_nxt     = '0;
    w_finish_store_nxt = 1'b0;
    w_finish_load_nxt  = 1'b0;
    w_ifetch_done_nxt  = 1'b0;
    w_data_load_nxt    = r_data_load;
    w_ifetch_inst_nxt  = r_ifetch_inst;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!roll_back) begin
          if (w_store_ok) begin
            w_state_nxt    = S_STORE;
            w_addr_nxt     = bus.store_address;
            w_wdata_hi_nxt = bus.data_store[31:8];
            w_op_nxt       = bus.op_type_store;
            w_len_nxt      = f_len(bus.op_type_store);
            w_mem_a_nxt    = bus.store_address;
            w_mem_wr_nxt   = 1'b1;
            w_mem_dout_nxt = bus.data_store[7:0];
          end else if (bus.lsb_load) begin
            w_state_nxt = S_LOAD;
            w_addr_nxt  = bus.load_address;
            w_op_nxt    = bus.op_type_load;
            w_len_nxt   = f_len(bus.op_type_load);
            w_mem_a_nxt = bus.load_address;
          end else if (bus.ifetch_req) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = bus.ifetch_addr;
            w_op_nxt    = OP_LW;
            w_len_nxt   = 3'd4;
            w_mem_a_nxt = bus.ifetch_addr;
          end
        end
      end

      S_STORE: begin
        if (r_cnt == r_len - 3'd1) begin
          w_state_nxt        = S_DONE;
          w_cnt_nxt          = '0;
          w_finish_store_nxt = 1'b1;
        end else begin
          w_cnt_nxt      = w_cnt_inc;
          w_mem_a_nxt    = w_addr_inc;
          w_mem_wr_nxt   = 1'b1;
          w_mem_dout_nxt = w_wbyte;
        end
      end

      // r_cnt counts addresses issued; byte r_cnt-1 is on mem_din this cycle.
      S_LOAD, S_FETCH: begin
        if (roll_back) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == r_len) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
          if (r_state == S_LOAD) begin
            w_finish_load_nxt = 1'b1;
            w_data_load_nxt   = f_extend(r_op, r_len, bus.mem_din, r_rbuf);
          end else begin
            w_ifetch_done_nxt = 1'b1;
            w_ifetch_inst_nxt = {bus.mem_din, r_rbuf};
          end
        end else begin
          case (r_cnt)
            3'd1:    w_rbuf_nxt[7:0]   = bus.mem_din;
            3'd2:    w_rbuf_nxt[15:8]  = bus.mem_din;
            3'd3:    w_rbuf_nxt[23:16] = bus.mem_din;
            default: w_rbuf_nxt        = r_rbuf;
          endcase
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc != r_len) w_mem_a_nxt = w_addr_inc;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_len          <= '0;
      r_addr         <= '0;
      r_wdata_hi     <= '0;
      r_op           <= '0;
      r_rbuf         <= '0;
      r_mem_a        <= '0;
      r_mem_wr       <= 1'b0;
      r_mem_dout     <= '0;
      r_finish_store <= 1'b0;
      r_finish_load  <= 1'b0;
      r_ifetch_done  <= 1'b0;
      r_data_load    <= '0;
      r_ifetch_inst  <= '0;
    end else if (rdy_in) begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_len          <= w_len_nxt;
      r_addr         <= w_addr_nxt;
      r_wdata_hi     <= w_wdata_hi_nxt;
      r_op           <= w_op_nxt;
      r_rbuf         <= w_rbuf_nxt;
      r_mem_a        <= w_mem_a_nxt;
      r_mem_wr       <= w_mem_wr_nxt;
      r_mem_dout     <= w_mem_dout_nxt;
      r_finish_store <= w_finish_store_nxt;
      r_finish_load  <= w_finish_load_nxt;
      r_ifetch_done  <= w_ifetch_done_nxt;
      r_data_load    <= w_data_load_nxt;
      r_ifetch_inst  <= w_ifetch_inst_nxt;
    end
  end

  assign bus.mem_a        = r_mem_a;
  assign bus.mem_wr       = r_mem_wr;
  assign bus.mem_dout     = r_mem_dout;
  assign bus.finish_store = r_finish_store;
  assign bus.finish_load  = r_finish_load;
  assign bus.ifetch_done  = r_ifetch_done;
  assign bus.data_load    = r_data_load;
  assign bus.ifetch_inst  = r_ifetch_inst;

endmodule
